// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared 4-bit add + decimal correct per clock,
// least-significant digit first, with start/busy/done sequencing.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;

  logic [3:0]      a_d;
  logic [3:0]      b_d;
  logic [4:0]      s;
  logic [3:0]      digit;
  logic            carry_nxt;
  logic            bad_digit;

  // Select the current digit pair and apply the decimal correction.
  always_comb begin
    a_d = 4'd0;
    b_d = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) begin
        a_d = a_q[4*i +: 4];
        b_d = b_q[4*i +: 4];
      end
    end
    s         = 5'(a_d) + 5'(b_d) + 5'(carry);
    carry_nxt = (s > 5'd9);
    digit     = carry_nxt ? 4'(s + 5'd6) : s[3:0];
    bad_digit = (a_d > 4'd9) || (b_d > 4'd9);
  end

  // Sequencer, datapath registers and registered status outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_bcd <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a_bcd;
            b_q     <= b_bcd;
            carry   <= cin;
            idx     <= '0;
            sum_bcd <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IW'(i)) sum_bcd[4*i +: 4] <= digit;
          end
          carry <= carry_nxt;
          err   <= err | bad_digit;
          if (idx == IW'(DIGITS - 1)) begin
            cout  <= carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4) with hand-computed results.
module tb_bcd_serial_add_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] a_bcd;
  logic [15:0] b_bcd;
  logic        cin;
  logic [15:0] sum_bcd;
  logic        cout;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .a_bcd   (a_bcd),
    .b_bcd   (b_bcd),
    .cin     (cin),
    .sum_bcd (sum_bcd),
    .cout    (cout),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  // Issue a one-cycle start, then follow busy for 4 cycles and done for 1.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_err);
    a_bcd = a; b_bcd = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      if (i == 1) begin
        // Operand changes after acceptance must not matter.
        a_bcd = 16'h5555; b_bcd = 16'h4444; cin = ~c;
      end
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_sum"}, {16'd0, sum_bcd}, {16'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    tick();
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_sum"}, {16'd0, sum_bcd}, {16'd0, exp_sum});
  endtask

  initial begin
    int done_cnt;
    resetn = 1'b0; start = 1'b0; a_bcd = '0; b_bcd = '0; cin = 1'b0;
    tick(); tick();
    check("rst_sum", {16'd0, sum_bcd}, 32'd0);
    check("rst_flags", {27'd0, cout, busy, done, err}, 32'd0);
    resetn = 1'b1;
    tick();

    run_op("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("t2", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t3", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op("t4a", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
    run_op("t4b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Start pulses while busy and in done are ignored.
    a_bcd = 16'h1234; b_bcd = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      start = (i == 1 || i == 2 || i == 4);
      if (done) done_cnt++;
      tick();
    end
    start = 1'b0;
    check("t5_one_done", done_cnt, 32'd1);
    check("t5_sum", {16'd0, sum_bcd}, 32'h6912);
    check("t5_idle", {30'd0, busy, done}, 32'd0);

    // Start held through done is accepted on the first idle edge.
    a_bcd = 16'h0011; b_bcd = 16'h0022; start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("t5h_done", {31'd0, done}, 32'd1);
    tick();
    check("t5h_idle", {30'd0, busy, done}, 32'd0);
    tick();
    check("t5h_restart", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5h_sum", {16'd0, sum_bcd}, 32'h0033);
    tick();

    // Reset mid-operation discards the partial result.
    a_bcd = 16'h1234; b_bcd = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t6_rst_sum", {16'd0, sum_bcd}, 32'd0);
    check("t6_rst_flags", {27'd0, cout, busy, done, err}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    check("t6_quiet", done_cnt, 32'd0);
    run_op("t6b", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
